fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a 2-entry prefetch buffer
//
// Purpose:
//   Drives the pc register and the instruction-memory read port, and buffers
//   returned instructions (with their addresses) for the decoder.
//   Memory has a fixed one-cycle read latency; at most one read is in flight.
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - asynchronous, active-low reset
//   pc_in          - current program count from the pc register
//   next_pc        - value to load into the pc register
//   pc_enable      - pc register load strobe
//   redirect_valid - one-cycle control-flow change request
//   redirect_addr  - redirect target
//   halt           - stops new fetch issue while 1
//   mem_rd         - instruction-memory read strobe
//   mem_addr       - instruction-memory read address
//   mem_data       - read data, valid the cycle after mem_rd
//   instr_valid    - head of buffer holds an instruction
//   instr_ready    - decoder accepts the head instruction this cycle
//   instr_data     - head instruction word
//   instr_pc       - address of the head instruction

module fetch_unit #(
  parameter int LENGTH      = 11,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LENGTH-1:0]      pc_in,
  output logic [LENGTH-1:0]      next_pc,
  output logic                   pc_enable,
  input  logic                   redirect_valid,
  input  logic [LENGTH-1:0]      redirect_addr,
  input  logic                   halt,
  output logic                   mem_rd,
  output logic [LENGTH-1:0]      mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [LENGTH-1:0]      instr_pc
);

  // Buffer storage and bookkeeping.
  logic [INSTR_WIDTH-1:0] buf_data_q [0:1];
  logic [LENGTH-1:0]      buf_pc_q   [0:1];
  logic [1:0]             count_q, count_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   inflight_q, inflight_d;
  logic [LENGTH-1:0]      inflight_pc_q, inflight_pc_d;

  // Per-cycle decisions.
  logic       pop;
  logic       redirect;
  logic       issue;
  logic       write;
  logic [2:0] occupancy;

  // Control decisions. Everything is gated by reset so that an asynchronous
  // reset assertion silences the pc and memory strobes immediately.
  always_comb begin
    instr_valid = (count_q != 2'd0);
    pop         = instr_valid & instr_ready;
    redirect    = reset & redirect_valid;
    // Slots that will be spoken for after this edge: buffered entries plus
    // the response still arriving, minus what the decoder takes now.
    occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue       = reset & ~redirect_valid & ~halt & (occupancy < 3'd2);
    // The in-flight response is dropped when a redirect arrives alongside it.
    write       = reset & inflight_q & ~redirect_valid;
  end

  // Pc register and memory port outputs.
  always_comb begin
    mem_rd    = 1'b0;
    mem_addr  = pc_in;
    pc_enable = 1'b0;
    next_pc   = pc_in;
    if (redirect) begin
      pc_enable = 1'b1;
      next_pc   = redirect_addr;
    end else if (issue) begin
      mem_rd    = 1'b1;
      pc_enable = 1'b1;
      next_pc   = pc_in + {{(LENGTH-1){1'b0}}, 1'b1};
    end
  end

  // Head entry drives the decoder straight from registers, never from mem_data.
  always_comb begin
    instr_data = buf_data_q[rd_ptr_q];
    instr_pc   = buf_pc_q[rd_ptr_q];
  end

  // Next-state bookkeeping.
  always_comb begin
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      // Flush wins over any pop, write or issue in the same cycle.
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      inflight_d = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_in;
      end
      if (write) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, write} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Entries are cleared on reset so the head reads as zero until first write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else if (write) begin
      buf_data_q[wr_ptr_q] <= mem_data;
      buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule
